// File: rtl/imem_loader.sv
// imem_loader: instruction-memory writer fed by a little-endian byte stream.
//
// Purpose: packs 4 bytes at a time into 32-bit instructions and issues
// one-cycle write strobes into instruction memory. While a load is in
// progress the pipeline is held in reset, so fetch only sees complete programs.
//
// Ports:
//   clock        system clock (rising edge)
//   reset        synchronous, active-high reset
//   start        one-cycle load request (honoured only in IDLE)
//   start_addr   first word address, sampled on accepted start
//   word_count   number of words to load, sampled on accepted start
//   byte_valid   source presents a byte on byte_data
//   byte_data    stream byte (first byte of a word is its LSB)
//   byte_ready   loader accepts a byte this cycle (decoded from state only)
//   mem_clear    one-cycle clear pulse to instruction memory
//   wr_en        one-cycle write strobe
//   wr_addr      write address (holds outside the write cycle)
//   wr_data      write data (holds outside the write cycle)
//   cpu_hold     pipeline reset request, high for the whole load
//   done         one-cycle pulse at end of load
//   error        sticky checksum-mismatch flag
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum
// byte (8-bit sum of all data bytes plus checksum must be 0). Without it,
// error is tied low and no trailing byte is consumed.

module imem_loader #(
    parameter int PC_SIZE = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_SIZE-1:0] start_addr,
    input  logic [PC_SIZE:0]   word_count,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               mem_clear,
    output logic               wr_en,
    output logic [PC_SIZE-1:0] wr_addr,
    output logic [31:0]        wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    localparam logic [PC_SIZE:0] DEPTH = {1'b1, {PC_SIZE{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RECV  = 3'd2,
        WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd5,
`endif
        DONE  = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [PC_SIZE-1:0] addr;
    logic [PC_SIZE:0]   remaining;
    logic [1:0]         byte_idx;
    logic [23:0]        partial;
    logic [PC_SIZE-1:0] wr_addr_q;
    logic [31:0]        wr_data_q;
    logic               accept;

    assign accept  = byte_valid && byte_ready;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_clear  = 1'b0;
        wr_en      = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                mem_clear  = 1'b1;
                cpu_hold   = 1'b1;
                state_next = (remaining != '0) ? RECV : DONE;
            end
            RECV: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                cpu_hold = 1'b1;
                // remaining still holds the pre-decrement count here
                if (remaining == (PC_SIZE+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) state_next = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                cpu_hold   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            partial   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr      <= start_addr;
                remaining <= (word_count > DEPTH) ? DEPTH : word_count;
                byte_idx  <= '0;
                partial   <= '0;
            end
            if (state == RECV && accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    partial[7:0]   <= byte_data;
                    2'd1:    partial[15:8]  <= byte_data;
                    2'd2:    partial[23:16] <= byte_data;
                    default: begin
                        // capture the full word so wr_* are valid during WRITE
                        wr_addr_q <= addr;
                        wr_data_q <= {byte_data, partial};
                    end
                endcase
            end
            if (state == WRITE) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                byte_idx  <= '0;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sum     <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                sum     <= '0;
                error_q <= 1'b0;
            end
            if (state == RECV && accept) begin
                sum <= sum + byte_data;
            end
            if (state == CHECK && accept && (sum + byte_data) != 8'h00) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (PC_SIZE=10).
// A negedge monitor logs every write strobe, clear pulse and done pulse;
// the directed sequence compares those logs and the live outputs against
// hand-computed values.

module tb_imem_loader;

    localparam int PC_SIZE = 10;

    logic               clock;
    logic               reset;
    logic               start;
    logic [PC_SIZE-1:0] start_addr;
    logic [PC_SIZE:0]   word_count;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               mem_clear;
    logic               wr_en;
    logic [PC_SIZE-1:0] wr_addr;
    logic [31:0]        wr_data;
    logic               cpu_hold;
    logic               done;
    logic               error;

    imem_loader #(.PC_SIZE(PC_SIZE)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_clear  (mem_clear),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [PC_SIZE-1:0] log_addr[$];
    logic [31:0]        log_data[$];
    int clear_cnt = 0;
    int done_cnt  = 0;
    int rdy_in_wr = 0;

    always @(negedge clock) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            if (byte_ready) rdy_in_wr++;
        end
        if (mem_clear) clear_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic logic [63:0] outs();
        return {16'h0, byte_ready, mem_clear, wr_en, cpu_hold, done, error,
                wr_addr, wr_data};
    endfunction

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        clear_cnt = 0;
        done_cnt  = 0;
        rdy_in_wr = 0;
    endtask

    // Returns after the edge at which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            step();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (byte_ready) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic do_start(input logic [PC_SIZE-1:0] a, input logic [PC_SIZE:0] n);
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        step();
        start      = 1'b0;
    endtask

    // Leaves the bench in the DONE cycle.
    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        byte_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    int c0;

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
        byte_valid = 1'b0; byte_data = '0;
        step(); step();
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b0;

        // Idle with byte_valid asserted: nothing moves.
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_outputs", outs(), 64'd0);
        end
        byte_valid = 1'b0;

        // Single word at address 5.
        clear_logs();
        c0 = cyc;
        do_start(10'd5, 11'd1);
        check("clear_pulse", {mem_clear, cpu_hold, byte_ready, wr_en}, 64'b1100);
        send_word(32'h00500013, 0);
        byte_valid = 1'b0;
        check("single_latency", 64'(cyc - c0), 64'd6);
        check("single_write", {wr_en, byte_ready, 22'h0, wr_addr, wr_data},
              {1'b1, 1'b0, 22'h0, 10'd5, 32'h00500013});
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h9D, 0);
        byte_valid = 1'b0;
`else
        step();
`endif
        check("single_done", {done, wr_en, cpu_hold}, 64'b101);
        step();
        check("single_idle", {done, cpu_hold, byte_ready, 22'h0, wr_addr},
              {3'b000, 22'h0, 10'd5});
        check("single_clear_cnt", 64'(clear_cnt), 64'd1);
        check("single_wr_cnt", 64'(log_addr.size()), 64'd1);
        check("single_error", 64'(error), 64'd0);

        // Three words from 0 with a gap before every byte.
        clear_logs();
        do_start(10'd0, 11'd3);
        send_word(32'h11223344, 1);
        send_word(32'hA5A55A5A, 1);
        send_word(32'hDEADBEEF, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1);
`endif
        wait_done(20);
        step();
        check("stall_wr_cnt", 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            check("stall_w0", {22'h0, log_addr[0], log_data[0]}, {22'h0, 10'd0, 32'h11223344});
            check("stall_w1", {22'h0, log_addr[1], log_data[1]}, {22'h0, 10'd1, 32'hA5A55A5A});
            check("stall_w2", {22'h0, log_addr[2], log_data[2]}, {22'h0, 10'd2, 32'hDEADBEEF});
        end
        check("ready_in_write", 64'(rdy_in_wr), 64'd0);
        check("stall_done_cnt", 64'(done_cnt), 64'd1);

        // Address wrap at the top of memory.
        clear_logs();
        do_start(10'd1022, 11'd3);
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) send_byte(8'(16 * w + k), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done(20);
        step();
        check("wrap_wr_cnt", 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            check("wrap_w0", {22'h0, log_addr[0], log_data[0]}, {22'h0, 10'd1022, 32'h03020100});
            check("wrap_w1", {22'h0, log_addr[1], log_data[1]}, {22'h0, 10'd1023, 32'h13121110});
            check("wrap_w2", {22'h0, log_addr[2], log_data[2]}, {22'h0, 10'd0,    32'h23222120});
        end

        // word_count larger than the memory clamps to 1024 words.
        clear_logs();
        do_start(10'd7, 11'd2047);
        for (int i = 0; i < 4096; i++) send_byte(8'(i), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done(20);
        step();
        check("clamp_wr_cnt", 64'(log_addr.size()), 64'd1024);
        if (log_addr.size() == 1024) begin
            check("clamp_first", {22'h0, log_addr[0], log_data[0]}, {22'h0, 10'd7, 32'h03020100});
            check("clamp_last", {22'h0, log_addr[1023], log_data[1023]}, {22'h0, 10'd6, 32'hFFFEFDFC});
        end
        byte_valid = 1'b1;
        step(); step(); step();
        check("clamp_no_extra", {byte_ready, cpu_hold, 30'h0, 32'(log_addr.size())},
              {2'b00, 30'h0, 32'd1024});
        byte_valid = 1'b0;

        // Zero-length load: clear pulse, then done, no writes.
        clear_logs();
        do_start(10'd3, 11'd0);
        check("zero_clear", {mem_clear, cpu_hold}, 64'b11);
        step();
        check("zero_done", {done, cpu_hold, wr_en}, 64'b110);
        step();
        check("zero_idle", {done, cpu_hold}, 64'b00);
        check("zero_wr_cnt", 64'(log_addr.size()), 64'd0);

        // Reset in the middle of a word aborts the load.
        clear_logs();
        do_start(10'd0, 11'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        reset = 1'b1;
        step();
        check("abort_outputs", outs(), 64'd0);
        reset = 1'b0;
        byte_valid = 1'b1;
        step(); step(); step(); step();
        check("abort_idle", outs(), 64'd0);
        check("abort_wr_cnt", 64'(log_addr.size()), 64'd0);
        byte_valid = 1'b0;

        // A start during RECV is ignored.
        clear_logs();
        do_start(10'd20, 11'd1);
        send_byte(8'hAA, 0);
        start      = 1'b1;
        start_addr = 10'd100;
        word_count = 11'd5;
        send_byte(8'hBB, 0);
        start      = 1'b0;
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        byte_valid = 1'b0;
        check("ign_write", {wr_en, 21'h0, 10'(wr_addr), wr_data},
              {1'b1, 21'h0, 10'd20, 32'hDDCCBBAA});
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hF2, 0);
        byte_valid = 1'b0;
`else
        step();
`endif
        check("ign_done", 64'(done), 64'd1);
        step();
        step(); step();
        check("ign_idle", {cpu_hold, byte_ready}, 64'b00);
        check("ign_wr_cnt", 64'(log_addr.size()), 64'd1);
        check("ign_clear_cnt", 64'(clear_cnt), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Matching checksum: 01+02+03+04+F6 = 0x100.
        do_start(10'd0, 11'd1);
        send_word(32'h04030201, 0);
        send_byte(8'hF6, 0);
        byte_valid = 1'b0;
        check("cks_ok_done", {done, error}, 64'b10);
        step();
        // Mismatch: sum + F5 = 0xFF.
        do_start(10'd0, 11'd1);
        send_word(32'h04030201, 0);
        send_byte(8'hF5, 0);
        byte_valid = 1'b0;
        check("cks_bad_done", {done, error}, 64'b11);
        step(); step(); step();
        check("cks_sticky", {cpu_hold, error}, 64'b01);
        do_start(10'd0, 11'd0);
        check("cks_cleared", 64'(error), 64'd0);
        step(); step();
`else
        check("no_cks_error", 64'(error), 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
